// File: rtl/async_fifo_write_arb.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define ASYNC_FIFO_ARB_STATS_EN to add saturating per-requester accepted-beat counters.
module async_fifo_write_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          write_clk,
  input  logic                          write_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          p_write_full,
  output logic                          p_write_en,
  output logic [DATA_WIDTH-1:0]         p_write_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clear,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_count
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 state_r;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [ID_W-1:0]        grant_id_r;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic                   wr_en_s;
  logic [DATA_WIDTH-1:0]  wr_data_s;
  logic                   accept_s;
  logic                   last_accept_s;
  logic [ID_W-1:0]        pick_s;
  logic [ID_W-1:0]        next_ptr_s;

  // First valid requester at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && vld[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

  // Arbitration pick and pointer advance derived from registered state.
  always_comb begin
    pick_s = rr_pick(req_valid, rr_ptr_r);
    if (grant_id_r == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = grant_id_r + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Zero-latency data path muxed from the registered owner.
  always_comb begin
    req_ready_s   = {NUM_REQ{1'b0}};
    wr_en_s       = 1'b0;
    wr_data_s     = {DATA_WIDTH{1'b0}};
    accept_s      = 1'b0;
    last_accept_s = 1'b0;
    if (state_r == ST_GRANT) begin
      req_ready_s[grant_id_r] = !p_write_full;
      accept_s                = req_valid[grant_id_r] && !p_write_full;
      last_accept_s           = accept_s && req_last[grant_id_r];
      wr_en_s                 = accept_s;
      wr_data_s               = req_data[grant_id_r*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      req_ready_s   = {NUM_REQ{1'b0}};
      wr_en_s       = 1'b0;
      wr_data_s     = {DATA_WIDTH{1'b0}};
      accept_s      = 1'b0;
      last_accept_s = 1'b0;
    end
  end

  // Grant FSM: lock on a requester until its last beat is written.
  always_ff @(posedge write_clk) begin
    if (!write_rst_n) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= {ID_W{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_id_r <= pick_s;
            state_r    <= ST_GRANT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (last_accept_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= next_ptr_s;
          end else begin
            state_r  <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_s;
  assign p_write_en   = wr_en_s;
  assign p_write_data = wr_data_s;
  assign grant_id     = grant_id_r;
  assign busy         = (state_r == ST_GRANT);

`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_r [NUM_REQ];

  // Saturating beat counters; clear has priority over a same-cycle increment.
  always_ff @(posedge write_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!write_rst_n || stat_clear) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end else if (accept_s && (grant_id_r == ID_W'(i)) && (cnt_r[i] != {CNT_WIDTH{1'b1}})) begin
        cnt_r[i] <= cnt_r[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    stat_count = {(NUM_REQ*CNT_WIDTH){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_write_arb.sv
// Scoreboard bench for async_fifo_write_arb: expected writes queued at stimulus time, popped on p_write_en.
module tb_async_fifo_write_arb;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            full;
  logic            p_write_en;
  logic [DW-1:0]   p_write_data;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic            stat_clear;
  logic [NR*CW-1:0] stat_count;
`endif

  async_fifo_write_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .write_clk(clk),
    .write_rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .p_write_full(full),
    .p_write_en(p_write_en),
    .p_write_data(p_write_data),
    .grant_id(grant_id),
    .busy(busy)
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    .stat_clear(stat_clear),
    .stat_count(stat_count)
`endif
  );

  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
  typedef struct packed { logic [1:0] id; logic [DW-1:0] data; } exp_t;

  beat_t       src [NR][$];
  exp_t        exp_q[$];
  logic [NR-1:0] hold;
  logic [31:0] en_hist;
  logic [NR-1:0] rdy_seen;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src[i].size() > 0 && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src[i][0].data;
        req_last[i]           = src[i][0].last;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  // Queue an n-beat packet for requester r; the first nexp beats are expected on the FIFO port.
  task automatic load_pkt(input int r, input int pkt, input int n, input int nexp);
    logic [DW-1:0] d;
    exp_t e;
    for (int b = 0; b < n; b++) begin
      d = {8'(r), 8'(pkt), 16'(b)};
      src[r].push_back({(b == n - 1), d});
      if (b < nexp) begin
        e.id   = 2'(r);
        e.data = d;
        exp_q.push_back(e);
      end
    end
    drive();
  endtask

  task automatic step();
    exp_t e;
    logic [NR-1:0] acc;
    logic [NR-1:0] onehot;
    @(negedge clk);
    en_hist  = {en_hist[30:0], p_write_en};
    rdy_seen = rdy_seen | req_ready;
    if (p_write_en) begin
      check_value("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        onehot = 4'b0001 << e.id;
        check_value("wr_data", 64'(p_write_data), 64'(e.data));
        check_value("grant_id", 64'(grant_id), 64'(e.id));
        check_value("ready_onehot", 64'(req_ready), 64'(onehot));
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) void'(src[i].pop_front());
    end
    drive();
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    int pend;
    n = 0;
    pend = exp_q.size() + src[0].size() + src[1].size() + src[2].size() + src[3].size();
    while (pend != 0 && n < max) begin
      step();
      n++;
      pend = exp_q.size() + src[0].size() + src[1].size() + src[2].size() + src[3].size();
    end
    check_value(tag, 64'(pend), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; full = 1'b0; hold = '0; en_hist = '0; rdy_seen = '0;
    req_valid = '0; req_data = '0; req_last = '0;
`ifdef ASYNC_FIFO_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    // All requesters valid during reset; expected order is the round-robin rotation.
    load_pkt(0, 0, 2, 2);
    load_pkt(1, 0, 2, 2);
    load_pkt(2, 0, 2, 2);
    load_pkt(3, 0, 2, 2);
    load_pkt(0, 1, 2, 2);
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_value("rst_busy", 64'(busy), 64'd0);
      check_value("rst_en", 64'(p_write_en), 64'd0);
      check_value("rst_ready", 64'(req_ready), 64'd0);
    end
    rst_n = 1'b1;
    step();
    check_value("first_busy", 64'(busy), 64'd1);
    check_value("first_grant", 64'(grant_id), 64'd0);
    en_hist = '0;
    repeat (15) step();
    check_value("rr_en_pattern", 64'(en_hist[14:0]), 64'(15'b110110110110110));
    drain("rr_drain", 40);

    // Packet lock: requester 1 stalls mid-packet while 2 waits.
    load_pkt(1, 2, 3, 3);
    load_pkt(2, 2, 1, 1);
    step();
    step();
    hold[1] = 1'b1;
    drive();
    en_hist = '0;
    repeat (2) step();
    check_value("lock_no_write", 64'(en_hist[1:0]), 64'd0);
    check_value("lock_busy", 64'(busy), 64'd1);
    check_value("lock_owner", 64'(grant_id), 64'd1);
    hold[1] = 1'b0;
    drive();
    drain("lock_drain", 40);

    // Full throttle mid-packet on requester 3.
    load_pkt(3, 3, 4, 4);
    step();
    step();
    full = 1'b1;
    en_hist = '0;
    rdy_seen = '0;
    repeat (4) step();
    check_value("full_no_en", 64'(en_hist[3:0]), 64'd0);
    check_value("full_no_ready", 64'(rdy_seen), 64'd0);
    full = 1'b0;
    drain("full_drain", 40);

    // Move rr_ptr to 2, then reset during beat 2 of a 4-beat packet from requester 3.
    load_pkt(1, 4, 1, 1);
    drain("pre_rst_drain", 20);
    load_pkt(3, 5, 4, 2);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    src[3].delete();
    drive();
    check_value("midrst_busy", 64'(busy), 64'd0);
    check_value("midrst_sb_empty", 64'(exp_q.size()), 64'd0);
    load_pkt(0, 6, 1, 1);
    load_pkt(3, 6, 1, 1);
    drain("post_rst_drain", 20);

`ifdef ASYNC_FIFO_ARB_STATS_EN
    check_value("stat_r0_after_rst", 64'(stat_count[0 +: CW]), 64'd1);
    check_value("stat_r3_after_rst", 64'(stat_count[3*CW +: CW]), 64'd1);
    load_pkt(2, 7, 20, 20);
    drain("stat_drain", 60);
    check_value("stat_sat", 64'(stat_count[2*CW +: CW]), 64'd15);
    load_pkt(2, 8, 2, 2);
    step();
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check_value("stat_clear", 64'(stat_count[2*CW +: CW]), 64'd0);
    drain("stat_clr_drain", 20);
    check_value("stat_after_clr", 64'(stat_count[2*CW +: CW]), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/async_fifo_write_arb.md
# async_fifo_write_arb

Round-robin, packet-locked arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the write clock domain. It grants one requester at a time and holds the grant until that requester's `last` beat is accepted. It forwards the granted requester's data and valid onto `p_write_en`/`p_write_data`, and throttles on `p_write_full`. The block sits directly in front of the FIFO write side and never advances the write pointer while the FIFO is full.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, FIFO word width
- CNT_WIDTH, 16, per-requester statistics counter width (used only with stats)

Ports:
- write_clk  in  1  write-domain clock
- write_rst_n  in  1  reset; synchronous and active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_ready  out  NUM_REQ  per-requester beat accepted when valid & ready
- p_write_full  in  1  FIFO full flag
- p_write_en  out  1  FIFO write enable
- p_write_data  out  DATA_WIDTH  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  index of current owner; valid only while busy
- busy  out  1  a grant is held
- stat_clear  in  1  clear all statistics counters (stats build only)
- stat_count  out  NUM_REQ*CNT_WIDTH  words accepted per requester (stats build only)

## Operation
State machine:
- States are IDLE and GRANT.
- IDLE, when any `req_valid` bit is set:
  - Select the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Register the winner into `grant_id`.
  - Move to GRANT.
- IDLE, when no `req_valid` bit is set: stay in IDLE.
- GRANT, beat acceptance:
  - A beat is accepted when `req_valid[g] && !p_write_full`, where g = `grant_id`.
  - When an accepted beat has `req_last[g]` set:
    - Move to IDLE.
    - Set `rr_ptr` to (g+1) mod NUM_REQ.

Outputs in GRANT:
- `req_ready[g]` = !`p_write_full`; all other ready bits are 0.
- `p_write_en` = `req_valid[g] && !p_write_full`.
- `p_write_data` = `req_data[g]` (combinational mux).

Outputs in IDLE:
- All `req_ready` bits = 0.
- `p_write_en` = 0.
- `p_write_data` = 0.

Behavioural rules:
- No requester other than g can write while GRANT is held, even if g deasserts valid mid-packet. The grant waits indefinitely.
- Requesters must not change data/last while valid && !ready. The arbiter does not check this.
- `busy` = (state == GRANT).

Reset (write_rst_n = 0 at a write_clk edge):
- State goes to IDLE; `rr_ptr` = 0; `grant_id` = 0; `busy` = 0.
- All `req_ready` bits = 0; `p_write_en` = 0; `p_write_data` = 0.
- Statistics counters = 0.
- Reset mid-packet drops the grant immediately, with no completion of the packet.

## Timing
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N gives GRANT and ready from cycle N+1.
- Between packets there is exactly 1 IDLE bubble cycle after each accepted last beat.
- Data path has zero latency: `p_write_en` and `p_write_data` are combinational from registered grant, `req_valid`, `req_data` and `p_write_full`.
- Full throttling: while `p_write_full` = 1, `p_write_en` = 0 and `req_ready` = 0 in the same cycle. Writing resumes the cycle `p_write_full` drops.
- Single-beat packet (valid && last on first beat): GRANT lasts 1 cycle if the FIFO is not full.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Configuration
- Macro: ASYNC_FIFO_ARB_STATS_EN.
- With the macro defined:
  - `stat_clear` and `stat_count` ports exist.
  - Counter i increments by 1 on every accepted beat of requester i.
  - Counters saturate at 2^CNT_WIDTH-1 with no wrap.
  - `stat_clear` is synchronous; clear wins over an increment in the same cycle.
- Without the macro:
  - The ports are absent.
  - No counter logic is generated.
  - All other behaviour is identical.

## Test plan
- Reset: hold write_rst_n = 0 for 3 cycles with all `req_valid` = 1 -> `busy` = 0, `p_write_en` = 0, `req_ready` = 0 throughout. Grant to requester 0 appears 1 cycle after release.
- Round-robin: all 4 requesters send continuous 2-beat packets -> grant order 0,1,2,3,0. Each packet is 2 `p_write_en` cycles followed by 1 idle cycle. `p_write_data` matches the owner's data each beat.
- Packet lock: requester 1 sends a 3-beat packet, deasserting valid for 2 cycles after beat 1, while requester 2 is valid -> no write from 2 until beat 3 (last) of requester 1 is accepted, then requester 2 is granted.
- Full throttle: `p_write_full` = 1 for 4 cycles mid-packet -> `p_write_en` = 0 and `req_ready` = 0 for those 4 cycles. Beat order is preserved and no data is lost.
- Reset mid-packet: assert write_rst_n = 0 during beat 2 of a 4-beat packet from requester 3 -> next cycle `busy` = 0 and `rr_ptr` = 0. Afterwards requester 0 wins over 3 when both are valid.
- Stats (ASYNC_FIFO_ARB_STATS_EN, CNT_WIDTH = 4): requester 2 sends 20 beats -> `stat_count[2]` = 15 (saturated). Asserting `stat_clear` in a cycle with an accepted beat -> the count is 0 on the next cycle.
